// File: rtl/gshare_ras_predictor.sv
// Dual-lane branch predictor for the preRR stage.
// Conditional branches use one gshare PHT indexed by PC ^ GHR.
// JALR returns are predicted from a return-address stack.
// Both lanes train from EX resolution. Prediction is combinational.
// PHT, GHR and RAS are registered.
module gshare_ras_predictor #(
    parameter int HIST_LEN  = 4,
    parameter int IDX_BITS  = 6,
    parameter int CTR_BITS  = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  alucode_reg1,
    input  logic [5:0]  alucode_reg2,
    input  logic [31:0] IFpc1,
    input  logic [31:0] IFpc2,
    input  logic [31:0] imm1,
    input  logic [31:0] imm2,
    input  logic        is_call1,
    input  logic        is_call2,
    input  logic        is_ret1,
    input  logic        is_ret2,
    input  logic        stall,
    input  logic        flush,
    input  logic [6:0]  opcodeRR1,
    input  logic [6:0]  opcodeRR2,
    input  logic [5:0]  alucodeRR1,
    input  logic [5:0]  alucodeRR2,
    input  logic [31:0] pcRR1,
    input  logic [31:0] pcRR2,
    input  logic        is_jump1,
    input  logic        is_jump2,
    output logic        pre_branch1,
    output logic        pre_branch2,
    output logic [31:0] predict_pc1,
    output logic [31:0] predict_pc2
);

    // ALU and opcode encodings shared with the core's decode tables
    localparam logic [5:0] ALU_BEQ    = 6'd18;
    localparam logic [5:0] ALU_BNE    = 6'd19;
    localparam logic [5:0] ALU_BLT    = 6'd20;
    localparam logic [5:0] ALU_BGE    = 6'd21;
    localparam logic [5:0] ALU_BLTU   = 6'd22;
    localparam logic [5:0] ALU_BGEU   = 6'd23;
    localparam logic [5:0] ALU_JAL    = 6'd24;
    localparam logic [5:0] ALU_JALR   = 6'd25;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;

    localparam int PHT_N = 1 << IDX_BITS;
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int THR_I = 1 << (CTR_BITS - 1);

    localparam logic [CTR_BITS-1:0] CTR_THR  = CTR_BITS'(THR_I);
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(THR_I - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [CTR_BITS-1:0] pht_q [PHT_N];
    logic [CTR_BITS-1:0] pht_d [PHT_N];
    logic [HIST_LEN-1:0] ghr_q, ghr_d;
    logic [31:0]         ras_q [RAS_DEPTH];
    logic [31:0]         ras_d [RAS_DEPTH];
    logic [PTR_W-1:0]    top_q, top_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [IDX_BITS-1:0] pidx1, pidx2, tidx1, tidx2;
    logic                train1, train2;
    logic [1:0]          lane_call, lane_ret, lane_en;
    logic [31:0]         lane_pc4 [2];
    logic                unused_rr;

    function automatic logic is_branch_code(input logic [5:0] code);
        return (code == ALU_BEQ)  || (code == ALU_BNE)  || (code == ALU_BLT) ||
               (code == ALU_BGE)  || (code == ALU_BLTU) || (code == ALU_BGEU);
    endfunction

    function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] c,
                                                      input logic taken);
        logic [CTR_BITS-1:0] r;
        r = c;
        if (taken && (c != CTR_MAX))
            r = c + 1'b1;
        else if (!taken && (c != '0))
            r = c - 1'b1;
        return r;
    endfunction

    // Works for HIST_LEN=1 too: the concatenation drops the old bit entirely.
    function automatic logic [HIST_LEN-1:0] ghr_shift(input logic [HIST_LEN-1:0] g,
                                                       input logic taken);
        logic [HIST_LEN:0] w;
        w = {g, taken};
        return w[HIST_LEN-1:0];
    endfunction

    function automatic logic [32:0] predict_lane(input logic [5:0]          code,
                                                 input logic [31:0]         pc,
                                                 input logic [31:0]         imm,
                                                 input logic                is_ret,
                                                 input logic [CTR_BITS-1:0] ctr);
        logic [31:0] seq_pc;
        logic [31:0] tgt_pc;
        logic [32:0] r;
        seq_pc = pc + 32'd4;
        tgt_pc = pc + imm;
        r = {1'b0, seq_pc};
        if (code == ALU_JAL)
            r = {1'b1, tgt_pc};
        else if (code == ALU_JALR)
            r = (is_ret && (cnt_q != '0)) ? {1'b1, ras_q[top_q]} : {1'b0, seq_pc};
        else if (is_branch_code(code))
            r = (ctr >= CTR_THR) ? {1'b1, tgt_pc} : {1'b0, seq_pc};
        return r;
    endfunction

    // Both lanes index with the registered GHR; no intra-bundle speculation.
    assign pidx1 = IFpc1[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
    assign pidx2 = IFpc2[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);

    assign {pre_branch1, predict_pc1} =
        predict_lane(alucode_reg1, IFpc1, imm1, is_ret1, pht_q[pidx1]);
    assign {pre_branch2, predict_pc2} =
        predict_lane(alucode_reg2, IFpc2, imm2, is_ret2, pht_q[pidx2]);

    assign train1 = (opcodeRR1 == OP_BRANCH) && is_branch_code(alucodeRR1);
    assign train2 = (opcodeRR2 == OP_BRANCH) && !is_jump1;

    assign lane_call   = {is_call2, is_call1};
    assign lane_ret    = {is_ret2, is_ret1};
    assign lane_en     = {~pre_branch1, 1'b1};
    assign lane_pc4[0] = IFpc1 + 32'd4;
    assign lane_pc4[1] = IFpc2 + 32'd4;

    assign unused_rr = ^{pcRR1[31:IDX_BITS+2], pcRR1[1:0],
                         pcRR2[31:IDX_BITS+2], pcRR2[1:0], alucodeRR2};

    // Sequential PHT/GHR training: lane2 sees lane1's counter and history.
    always_comb begin
        pht_d = pht_q;
        ghr_d = ghr_q;
        tidx1 = '0;
        tidx2 = '0;
        if (train1) begin
            tidx1        = pcRR1[IDX_BITS+1:2] ^ IDX_BITS'(ghr_d);
            pht_d[tidx1] = ctr_step(pht_d[tidx1], is_jump1);
            ghr_d        = ghr_shift(ghr_d, is_jump1);
        end
        if (train2) begin
            tidx2        = pcRR2[IDX_BITS+1:2] ^ IDX_BITS'(ghr_d);
            pht_d[tidx2] = ctr_step(pht_d[tidx2], is_jump2);
            ghr_d        = ghr_shift(ghr_d, is_jump2);
        end
    end

    // RAS next state: lane1 then lane2 in order, flush overrides everything.
    always_comb begin
        ras_d = ras_q;
        top_d = top_q;
        cnt_d = cnt_q;
        if (!stall) begin
            for (int l = 0; l < 2; l++) begin
                if (lane_en[l]) begin
                    if (lane_call[l] && (!lane_ret[l] || (cnt_d == '0))) begin
                        top_d        = top_d + 1'b1;
                        ras_d[top_d] = lane_pc4[l];
                        if (cnt_d != CNT_FULL)
                            cnt_d = cnt_d + 1'b1;
                    end else if (lane_call[l]) begin
                        ras_d[top_d] = lane_pc4[l];
                    end else if (lane_ret[l] && (cnt_d != '0)) begin
                        top_d = top_d - 1'b1;
                        cnt_d = cnt_d - 1'b1;
                    end
                end
            end
        end
        if (flush) begin
            top_d = '0;
            cnt_d = '0;
        end
    end

    // State registers; reset puts every counter at weakly not-taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PHT_N; i++)
                pht_q[i] <= CTR_INIT;
            for (int i = 0; i < RAS_DEPTH; i++)
                ras_q[i] <= '0;
            ghr_q <= '0;
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            pht_q <= pht_d;
            ras_q <= ras_d;
            ghr_q <= ghr_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: doc/gshare_ras_predictor.md
Name: gshare_ras_predictor

Overview:
- Dual-lane branch predictor; successor to the per-type history predictor in the preRR stage.
- Conditional branches: one gshare pattern-history table (PHT) indexed by PC XOR global history register (GHR).
- Adds a return-address stack (RAS) for JALR returns.
- Trains from EX-stage resolution on both lanes. Prediction is combinational; PHT, GHR and RAS are sequential.

Parameters:
- HIST_LEN, 4, GHR width in bits; must satisfy 1 <= HIST_LEN <= IDX_BITS.
- IDX_BITS, 6, PHT index width; the PHT has 2^IDX_BITS entries.
- CTR_BITS, 2, saturating counter width; predict taken when counter >= 2^(CTR_BITS-1).
- RAS_DEPTH, 4, RAS entries; must be a power of two and >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- alucode_reg1/2  in  6  preRR ALU code per lane (`ALU_* from define.vh)
- IFpc1/2  in  32  preRR PC per lane
- imm1/2  in  32  preRR immediate per lane
- is_call1/2  in  1  preRR instruction is JAL/JALR with rd=x1/x5
- is_ret1/2  in  1  preRR instruction is JALR with rs1=x1/x5
- stall  in  1  freeze RAS updates from preRR
- flush  in  1  pipeline redirect; empties RAS
- opcodeRR1/2  in  7  EX opcode per lane
- alucodeRR1/2  in  6  EX ALU code per lane
- pcRR1/2  in  32  EX PC per lane
- is_jump1/2  in  1  EX resolved taken
- pre_branch1/2  out  1  predicted taken
- predict_pc1/2  out  32  predicted next PC

Behaviour:
- Reset (rst=0, asynchronous):
  - all PHT counters = 2^(CTR_BITS-1)-1 (weakly not-taken; 1 for CTR_BITS=2);
  - GHR=0; RAS count=0, top pointer=0.
- Outputs during reset are driven combinationally from the reset state:
  - branch and JALR lanes give pre_branch=0, predict_pc=IFpc+4;
  - JAL gives pre_branch=1, predict_pc=IFpc+imm.
- PHT index:
  - idx(pc) = pc[IDX_BITS+1:2] XOR zero-extended GHR.
  - Both prediction lanes use the current registered GHR; there is no intra-bundle speculative history.
- Prediction per lane (combinational, zero latency):
  - JAL: taken, target IFpc+imm.
  - JALR with is_ret and RAS count>0: taken, target = RAS[top].
  - Other JALR: not taken, target IFpc+4.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: taken iff PHT[idx(IFpc)] >= threshold; target IFpc+imm if taken, else IFpc+4.
  - Any other code: not taken, target IFpc+4.
- RAS update (posedge; skipped entirely when stall=1):
  - Lanes are processed in order lane1 then lane2. Lane2 ops are suppressed when pre_branch1=1.
  - Call only: top advances (mod RAS_DEPTH) and IFpc+4 is written there; count = min(count+1, RAS_DEPTH).
  - Overflow overwrites the oldest entry.
  - Return only, count>0: top retreats and count decrements. Return with count=0: no change.
  - Call and return together: RAS[top] is replaced with IFpc+4; count unchanged. If count=0, this acts as a push.
  - Lane2 sees lane1's result within the same cycle.
  - flush=1 has priority over stall and all ops: count=0, top=0.
- Training (posedge, independent of stall/flush):
  - Lane1 trains when opcodeRR1==`BRANCH and alucodeRR1 is a branch code.
  - Lane2 trains when opcodeRR2==`BRANCH and is_jump1=0.
  - Counter update saturates: taken increments to max 2^CTR_BITS-1; not-taken decrements to min 0.
  - Lane1 PHT index uses the old GHR; afterwards GHR = {GHR[HIST_LEN-2:0], is_jump1}.
  - Lane2 index uses the post-lane1 GHR, then shifts in is_jump2. With HIST_LEN=1 the GHR is simply replaced.
  - Same-index dual update composes sequentially: e.g. 1 -> 2 (taken) -> 3 (taken).
  - A JAL/JALR resolving in EX trains nothing.
- Reset asserted mid-operation overrides any pending update in that cycle.

Test Plan:
- Release reset; BEQ at IFpc1=0x100, imm1=0x40 -> pre_branch1=0, predict_pc1=0x104. JAL imm=0x20 at 0x200 -> pre_branch=1, target 0x220.
- Train lane1 BNE at pcRR1=0x40, taken twice, GHR starting 0 (idx 0x10, then 0x11 after shift) -> GHR=4'b0011. Predicting at 0x40 with GHR=0x3 uses idx 0x13 (untrained) -> not taken. Retrain until idx 0x13 >= 2 -> taken.
- Same cycle: lane1 BEQ not-taken and lane2 BEQ taken, both mapping to the same PHT entry at value 1 -> final value 1 (0 then 1). GHR shifts 0 then 1. Repeat with is_jump1=1 -> lane2 is ignored.
- Five calls at 0x10, 0x20, 0x30, 0x40, 0x50 (RAS_DEPTH=4), then returns:
  - first four returns predict 0x54, 0x44, 0x34, 0x24;
  - fifth return predicts not-taken (IFpc+4).
  - A call with stall=1 leaves the RAS unchanged.
- Lane1 JAL call at 0x80 predicted taken plus lane2 call -> only 0x84 is pushed. flush=1 in the same cycle as a push -> count=0 and the next return is not taken.
- Assert rst mid-training with all counters at 3 -> every counter reads 1 immediately (asynchronous) and GHR=0.
